// File: rtl/counter_seq_checker_pkg.sv
// Shared definitions for the up/down counter sequence checker:
// FSM state encoding and default build widths.
package counter_seq_checker_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

endpackage

// File: rtl/counter_ref_model.sv
// Reference copy of the loadable up/down counter. On a mismatch the next value
// is computed from the observed Q, so a single upset is reported only once.
module counter_ref_model
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_synced,
    input  logic             i_ce,
    input  logic             i_sclr,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_l,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_exp_q,
    output logic             o_mismatch
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_exp_q;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;
    logic             w_mismatch;

    assign w_mismatch = i_synced && (i_q != r_exp_q);
    assign w_base     = w_mismatch ? i_q : r_exp_q;

    // Next model value: SCLR over LOAD over count direction, all gated by CE.
    always_comb begin
        w_next = w_base;
        if (i_ce) begin
            if (i_sclr) begin
                w_next = {WIDTH{1'b0}};
            end else if (i_load) begin
                w_next = i_l;
            end else if (i_up) begin
                w_next = w_base + ONE;
            end else begin
                w_next = w_base - ONE;
            end
        end else begin
            w_next = w_base;
        end
    end

    // Model register, advanced on the same edge as the real counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exp_q <= {WIDTH{1'b0}};
        end else begin
            r_exp_q <= w_next;
        end
    end

    assign o_exp_q    = r_exp_q;
    assign o_mismatch = w_mismatch;

endmodule

// File: rtl/counter_seq_checker.sv
// Passive checker for the loadable up/down counter: tracks a reference model,
// flags Q divergence and keeps sticky/count/first-failure status for probing.
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 CE,
    input  logic                 SCLR,
    input  logic                 UP,
    input  logic                 LOAD,
    input  logic [WIDTH-1:0]     L,
    input  logic [WIDTH-1:0]     Q,
    input  logic                 clr_err,
    output logic                 synced,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_obs
);

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_synced;
    logic                 r_err_pulse;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [WIDTH-1:0]     r_first_exp;
    logic [WIDTH-1:0]     r_first_obs;
    logic [WIDTH-1:0]     w_exp_q;
    logic                 w_mismatch;
    logic                 w_capture;

    counter_ref_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .clk        (clk),
        .resetn     (resetn),
        .i_synced   (r_synced),
        .i_ce       (CE),
        .i_sclr     (SCLR),
        .i_up       (UP),
        .i_load     (LOAD),
        .i_l        (L),
        .i_q        (Q),
        .o_exp_q    (w_exp_q),
        .o_mismatch (w_mismatch)
    );

    // Snapshot only the first failure; a coincident clr_err re-arms capture.
    assign w_capture = w_mismatch && (!r_err_sticky || clr_err);

    // Next-state logic: sync on a defining write, then TRACK/FAULT forever.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_UNSYNC: begin
                if (CE && (SCLR || LOAD)) begin
                    w_state_next = ST_TRACK;
                end else begin
                    w_state_next = ST_UNSYNC;
                end
            end
            ST_TRACK: begin
                if (w_mismatch) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_state_next = ST_TRACK;
                end
            end
            ST_FAULT: begin
                if (clr_err && !w_mismatch) begin
                    w_state_next = ST_TRACK;
                end else begin
                    w_state_next = ST_FAULT;
                end
            end
            default: begin
                w_state_next = ST_UNSYNC;
            end
        endcase
    end

    // State register with a registered copy of the synced flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_UNSYNC;
            r_synced <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_synced <= (w_state_next != ST_UNSYNC);
        end
    end

    // Error status: a new mismatch always wins over a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= {ERR_CNT_W{1'b0}};
        end else begin
            r_err_pulse <= w_mismatch;
            if (w_mismatch) begin
                r_err_sticky <= 1'b1;
            end else if (clr_err) begin
                r_err_sticky <= 1'b0;
            end else begin
                r_err_sticky <= r_err_sticky;
            end
            if (clr_err) begin
                r_err_count <= w_mismatch ? CNT_ONE : {ERR_CNT_W{1'b0}};
            end else if (w_mismatch && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end else begin
                r_err_count <= r_err_count;
            end
        end
    end

    // First-failure snapshot registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_first_exp <= {WIDTH{1'b0}};
            r_first_obs <= {WIDTH{1'b0}};
        end else if (w_capture) begin
            r_first_exp <= w_exp_q;
            r_first_obs <= Q;
        end else if (clr_err) begin
            r_first_exp <= {WIDTH{1'b0}};
            r_first_obs <= {WIDTH{1'b0}};
        end else begin
            r_first_exp <= r_first_exp;
            r_first_obs <= r_first_obs;
        end
    end

    assign synced     = r_synced;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;
    assign first_exp  = r_first_exp;
    assign first_obs  = r_first_obs;

endmodule

// File: doc/counter_seq_checker.md
Name: counter_seq_checker

Overview:
- Passive checker for the loadable up/down counter used in the HW debug designs.
- Taps the same CE/SCLR/UP/LOAD/L controls that drive the counter, plus the counter's Q output.
- Keeps a reference model of the counter and flags any cycle where Q differs from the model.
- Error flags, a counter and a first-failure snapshot are exported for ILA/VIO probing.

Parameters:
WIDTH, 32, counter data width (L, Q, model, snapshots)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  single clock, same clock as the checked counter
resetn  in  1  asynchronous active-low reset
CE  in  1  counter clock enable (same net as the counter)
SCLR  in  1  counter synchronous clear
UP  in  1  counter direction (1 = increment, 0 = decrement)
LOAD  in  1  counter parallel load
L  in  WIDTH  counter load value
Q  in  WIDTH  observed counter output
clr_err  in  1  synchronous clear of error status
synced  out  1  model holds a known value; comparisons are active
err_pulse  out  1  one-cycle pulse per detected mismatch
err_sticky  out  1  set on the first mismatch, held until clr_err
err_count  out  ERR_CNT_W  saturating mismatch count
first_exp  out  WIDTH  model value at the first mismatch
first_obs  out  WIDTH  Q value at the first mismatch

Behaviour:
- Reset (resetn=0, asynchronous):
  - All outputs go to 0; model exp_q = 0.
  - FSM enters UNSYNC.
  - Reset mid-operation discards all history.
- Model update, every rising clk:
  - Base value b = Q on a mismatch cycle, otherwise exp_q. On a mismatch the model re-seeds from observed Q, so one glitch produces one error.
  - If CE=1, priority is SCLR -> 0, then LOAD -> L, then UP -> b+1, then down -> b-1.
  - Arithmetic is modulo 2^WIDTH: all-ones + 1 = 0, and 0 - 1 = all-ones.
  - If CE=0, exp_q = b.
- Alignment:
  - The model updates on the same edge as the counter, so exp_q and Q refer to the same cycle.
  - mismatch (combinational) = synced AND (Q != exp_q).
- FSM states: UNSYNC, TRACK, FAULT. synced = (state != UNSYNC).
  - UNSYNC -> TRACK on an edge with CE=1 AND (SCLR OR LOAD). No comparisons are made in UNSYNC; an arbitrary power-up Q is tolerated.
  - TRACK -> FAULT on an edge where mismatch=1.
  - FAULT -> TRACK on an edge with clr_err=1 AND mismatch=0.
  - FAULT stays in FAULT on further mismatches.
  - TRACK and FAULT never return to UNSYNC except via reset.
- Error outputs, registered:
  - A mismatch visible in cycle k gives err_pulse=1 in cycle k+1.
  - err_sticky is set in that same cycle k+1.
  - err_count increments by 1 per mismatch and saturates at all-ones; it never wraps.
  - first_exp/first_obs capture exp_q/Q only on a mismatch edge while err_sticky=0 (or while clr_err is clearing it).
- clr_err:
  - Clears err_sticky, err_count, first_exp and first_obs to 0.
  - If clr_err and mismatch coincide, the new mismatch wins: err_sticky=1, err_count=1, snapshots take the new values, and the state stays FAULT.
  - clr_err in UNSYNC clears status only.
- Simultaneous SCLR+LOAD+UP: SCLR dominates, exactly as in the counter.
- The block is purely observational: no combinational path from inputs to outputs, and no back-pressure on the counter.

Decomposition:
- Shared package holds:
  - FSM state encoding: ST_UNSYNC=2'd0, ST_TRACK=2'd1, ST_FAULT=2'd2.
  - Default WIDTH and ERR_CNT_W constants.
- One natural sub-module: counter_ref_model, holding exp_q and the next-value function (CE/SCLR/LOAD/UP priority and the re-seed mux).
- The FSM, error counter and snapshot logic stay in the top module.

Test Plan:
- Power-up Q=0x1234 with no SCLR/LOAD for 10 cycles -> synced=0, err_pulse never asserted. Then CE=1,SCLR=1 for one cycle -> synced=1 next cycle.
- LOAD L=0xFFFFFFFE, then UP=1 for 4 cycles, with the counter behaving correctly (Q wraps 0xFFFFFFFF -> 0x0 -> 0x1) -> err_count stays 0, state TRACK.
- In TRACK at exp=0x10, force Q=0x55 for one cycle:
  - err_pulse high for exactly one cycle, the next cycle.
  - err_sticky=1, err_count=1, first_exp=0x10, first_obs=0x55.
  - Model re-seeds, so no further errors while Q tracks.
- Hold Q constant while UP=1,CE=1 for 2^ERR_CNT_W+5 cycles (ERR_CNT_W=4 build) -> err_count saturates at 0xF, err_pulse every cycle.
- clr_err asserted on the same cycle as a new mismatch -> err_count=1, err_sticky=1, snapshots updated, state FAULT. clr_err alone next cycle -> all cleared, state TRACK.
- Assert resetn=0 mid-count while in FAULT -> all outputs 0 immediately (asynchronous), state UNSYNC, no errors until the next SCLR/LOAD.
